timer_irq_ctrl: RTL and testbench

//   Parametrised multi-channel timer interrupt source; replaces the single bench-driven int_timer pulse.
//   NUM_CH down-counters share one prescaler. Each channel runs one-shot or periodic and latches a pending flag on expiry.

---
 rtl/timer_irq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_timer_irq_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_ctrl.sv
// Multi-channel timer interrupt source: NUM_CH down-counters on a shared prescaler,
// per-channel pending/overrun flags and a registered, priority-encoded interrupt request.
//   state   | meaning
//   ST_IDLE | channel disabled, counter frozen
//   ST_RUN  | channel enabled, counting down on each prescaler tick
module timer_irq_ctrl #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PRESC  = 1,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [CH_W-1:0]   i_wr_ch,
  input  logic              i_wr_sel,
  input  logic [CNT_W-1:0]  i_wr_data,
  input  logic              i_ack,
  input  logic [CH_W-1:0]   i_ack_ch,
  output logic              o_int_timer,
  output logic [CH_W-1:0]   o_int_id,
  output logic [NUM_CH-1:0] o_pending,
  output logic [NUM_CH-1:0] o_overrun
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_t;

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [PW-1:0]     r_presc;
  logic              w_tick;
  logic [NUM_CH-1:0] w_pend_vec;
  logic [NUM_CH-1:0] w_mask_vec;
  logic [NUM_CH-1:0] w_irq_vec;
  logic [CH_W-1:0]   w_irq_id;

  assign w_tick = (r_presc == PW'(PRESC - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_t        r_state;
    ch_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_load;
    logic [CNT_W-1:0] w_load_nxt;
    logic             r_periodic;
    logic             w_periodic_nxt;
    logic             r_mask;
    logic             w_mask_nxt;
    logic             r_pend;
    logic             w_pend_nxt;
    logic             r_ovr;
    logic             w_ovr_nxt;
    logic             w_expire;
    logic             w_ld_hit;
    logic             w_ctl_hit;
    logic             w_ack_hit;

    // Out-of-range channel numbers simply never match any g.
    assign w_ld_hit  = i_wr_en && !i_wr_sel && (i_wr_ch == CH_W'(g));
    assign w_ctl_hit = i_wr_en &&  i_wr_sel && (i_wr_ch == CH_W'(g));
    assign w_ack_hit = i_ack && (i_ack_ch == CH_W'(g));

    always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_load_nxt     = r_load;
      w_periodic_nxt = r_periodic;
      w_mask_nxt     = r_mask;
      w_pend_nxt     = r_pend;
      w_ovr_nxt      = r_ovr;
      w_expire       = 1'b0;

      if (w_ld_hit) begin
        w_load_nxt = i_wr_data;
      end
      if (w_ctl_hit) begin
        w_periodic_nxt = i_wr_data[1];
        w_mask_nxt     = i_wr_data[2];
      end

      case (r_state)
        ST_IDLE: begin
          if (w_ctl_hit && i_wr_data[0]) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = r_load;
          end
        end
        ST_RUN: begin
          if (w_ctl_hit && !i_wr_data[0]) begin
            w_state_nxt = ST_IDLE;
          end else if (w_tick) begin
            if (r_cnt != '0) begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
              w_expire = 1'b1;
              if (r_periodic) begin
                w_cnt_nxt = r_load;
              end else begin
                w_state_nxt = ST_IDLE;
              end
            end
          end
        end
      endcase

      // Expiry beats a same-edge ack so the event is never lost.
      if (w_expire) begin
        w_pend_nxt = 1'b1;
        if (r_pend && !w_ack_hit) begin
          w_ovr_nxt = 1'b1;
        end
      end else if (w_ack_hit) begin
        w_pend_nxt = 1'b0;
        w_ovr_nxt  = 1'b0;
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_state    <= ST_IDLE;
        r_cnt      <= '0;
        r_load     <= '0;
        r_periodic <= 1'b0;
        r_mask     <= 1'b0;
        r_pend     <= 1'b0;
        r_ovr      <= 1'b0;
      end else begin
        r_state    <= w_state_nxt;
        r_cnt      <= w_cnt_nxt;
        r_load     <= w_load_nxt;
        r_periodic <= w_periodic_nxt;
        r_mask     <= w_mask_nxt;
        r_pend     <= w_pend_nxt;
        r_ovr      <= w_ovr_nxt;
      end
    end

    assign w_pend_vec[g] = r_pend;
    assign w_mask_vec[g] = r_mask;
    assign o_overrun[g]  = r_ovr;
  end

  assign o_pending = w_pend_vec;
  assign w_irq_vec = w_pend_vec & w_mask_vec;

  always_comb begin
    w_irq_id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_irq_vec[i]) begin
        w_irq_id = CH_W'(i);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_int_timer <= 1'b0;
      o_int_id    <= '0;
    end else begin
      o_int_timer <= |w_irq_vec;
      o_int_id    <= w_irq_id;
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl: one instance at PRESC=1, a second at PRESC=4.
module tb_timer_irq_ctrl;

  localparam int CH_W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic        wr_sel;
  logic [15:0] wr_data;
  logic        ack;
  logic [1:0]  ack_ch;

  logic        int_timer,   int_timer_b;
  logic [1:0]  int_id,      int_id_b;
  logic [3:0]  pend,        pend_b;
  logic [3:0]  ovr,         ovr_b;

  int n_checks = 0;
  int n_errors = 0;

  timer_irq_ctrl #(.NUM_CH(4), .CNT_W(16), .PRESC(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_ch(wr_ch), .i_wr_sel(wr_sel),
    .i_wr_data(wr_data), .i_ack(ack), .i_ack_ch(ack_ch),
    .o_int_timer(int_timer), .o_int_id(int_id), .o_pending(pend), .o_overrun(ovr)
  );

  timer_irq_ctrl #(.NUM_CH(4), .CNT_W(16), .PRESC(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_ch(wr_ch), .i_wr_sel(wr_sel),
    .i_wr_data(wr_data), .i_ack(ack), .i_ack_ch(ack_ch),
    .o_int_timer(int_timer_b), .o_int_id(int_id_b), .o_pending(pend_b), .o_overrun(ovr_b)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int ch, input logic sel, input int data);
    wr_en   = 1'b1;
    wr_ch   = ch[CH_W-1:0];
    wr_sel  = sel;
    wr_data = data[15:0];
    step(1);
    wr_en   = 1'b0;
  endtask

  task automatic do_ack(input int ch);
    ack    = 1'b1;
    ack_ch = ch[CH_W-1:0];
    step(1);
    ack    = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_sel = 1'b0; wr_data = '0; ack = 1'b0; ack_ch = '0;
    step(2);
    chk("rst_pend",    32'(pend),      0);
    chk("rst_ovr",     32'(ovr),       0);
    chk("rst_int",     32'(int_timer), 0);
    chk("rst_id",      32'(int_id),    0);
    chk("rst_b_pend",  32'(pend_b),    0);
    rst = 1'b0;
    step(1);

    // 1: ch0 periodic LOAD=3, CTRL at E0
    wr(0, 1'b0, 3);
    wr(0, 1'b1, 7);
    chk("t1_e0_pend",  32'(pend), 0);
    step(3);
    chk("t1_e3_pend",  32'(pend[0]), 0);
    step(1);
    chk("t1_e4_pend",  32'(pend[0]), 1);
    chk("t1_e4_int",   32'(int_timer), 0);
    step(1);
    chk("t1_e5_int",   32'(int_timer), 1);
    chk("t1_e5_id",    32'(int_id), 0);
    do_ack(0);
    chk("t1_ack_pend", 32'(pend[0]), 0);
    step(2);
    chk("t1_e8_pend",  32'(pend[0]), 1);
    chk("t1_e8_ovr",   32'(ovr[0]), 0);
    wr(0, 1'b1, 0);
    do_ack(0);
    step(1);
    chk("t1_off_pend", 32'(pend), 0);
    chk("t1_off_int",  32'(int_timer), 0);

    // 2: ch1 one-shot LOAD=0
    wr(1, 1'b0, 0);
    wr(1, 1'b1, 5);
    chk("t2_w_pend",   32'(pend[1]), 0);
    step(1);
    chk("t2_exp_pend", 32'(pend[1]), 1);
    chk("t2_exp_ovr",  32'(ovr), 0);
    do_ack(1);
    step(50);
    chk("t2_quiet",    32'(pend), 0);
    chk("t2_quiet_int",32'(int_timer), 0);

    // 3: ch2/ch3 periodic LOAD=5, priority and ack sequencing
    wr(2, 1'b0, 5);
    wr(3, 1'b0, 5);
    wr(2, 1'b1, 7);
    wr(3, 1'b1, 7);
    step(6);
    chk("t3_pend",     32'(pend), 32'hC);
    chk("t3_id2",      32'(int_id), 2);
    chk("t3_int",      32'(int_timer), 1);
    do_ack(2);
    step(1);
    chk("t3_id3",      32'(int_id), 3);
    chk("t3_int3",     32'(int_timer), 1);
    do_ack(3);
    step(1);
    chk("t3_int_off",  32'(int_timer), 0);
    chk("t3_pend_off", 32'(pend), 0);
    step(1);
    wr(2, 1'b1, 0);
    wr(3, 1'b1, 0);
    do_ack(2);
    do_ack(3);
    step(1);
    chk("t3_clean",    32'(pend), 0);
    chk("t3_clean_ovr",32'(ovr), 0);

    // 4: ack on expiry edge keeps pending, then overrun
    wr(0, 1'b0, 2);
    wr(0, 1'b1, 7);
    step(2);
    chk("t4_pre",      32'(pend[0]), 0);
    step(1);
    chk("t4_exp1",     32'(pend[0]), 1);
    step(2);
    ack = 1'b1; ack_ch = 2'd0;
    step(1);
    ack = 1'b0;
    chk("t4_race_pend",32'(pend[0]), 1);
    chk("t4_race_ovr", 32'(ovr[0]), 0);
    step(3);
    chk("t4_ovr",      32'(ovr[0]), 1);
    chk("t4_ovr_pend", 32'(pend[0]), 1);
    do_ack(0);
    chk("t4_ack_pend", 32'(pend[0]), 0);
    chk("t4_ack_ovr",  32'(ovr[0]), 0);
    wr(0, 1'b1, 0);

    // 5: masked channel still pends, unmask raises irq one cycle later
    wr(1, 1'b0, 1);
    wr(1, 1'b1, 3);
    step(2);
    chk("t5_pend",     32'(pend[1]), 1);
    step(1);
    chk("t5_masked",   32'(int_timer), 0);
    wr(1, 1'b1, 7);
    chk("t5_ovr",      32'(ovr[1]), 1);
    chk("t5_still0",   32'(int_timer), 0);
    step(1);
    chk("t5_int",      32'(int_timer), 1);
    chk("t5_id",       32'(int_id), 1);
    step(1);
    wr(1, 1'b1, 0);
    do_ack(1);
    step(1);

    // 6: PRESC=4 instance, 8-cycle period, async reset mid-count
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    wr(0, 1'b0, 1);
    wr(0, 1'b1, 7);
    step(5);
    chk("t6_r7_pend",  32'(pend_b[0]), 0);
    step(1);
    chk("t6_r8_pend",  32'(pend_b[0]), 1);
    do_ack(0);
    step(6);
    chk("t6_r15_pend", 32'(pend_b[0]), 0);
    step(1);
    chk("t6_r16_pend", 32'(pend_b[0]), 1);
    step(2);
    chk("t6_int_pre",  32'(int_timer_b), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_pend", 32'(pend_b), 0);
    chk("t6_rst_ovr",  32'(ovr_b), 0);
    chk("t6_rst_int",  32'(int_timer_b), 0);
    chk("t6_rst_id",   32'(int_id_b), 0);
    step(2);
    rst = 1'b0;
    step(20);
    chk("t6_quiet",    32'(pend_b), 0);
    chk("t6_quiet_int",32'(int_timer_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
